chunked_add_sequencer: RTL and testbench



---
 rtl/chunked_add_sequencer.sv | 115 +++++++++++
 tb/tb_chunked_add_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_add_sequencer.sv
// Multi-cycle wide adder controller: streams N-bit chunks LSB-first through an external adder.
// Optional A-B mode is enabled by defining CHUNKED_ADD_SUB_EN (adds the in_sub port).
module chunked_add_sequencer #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   in_a,
    input  logic [N*WORDS-1:0]   in_b,
    input  logic                 in_cin,
`ifdef CHUNKED_ADD_SUB_EN
    input  logic                 in_sub,
`endif
    output logic [N-1:0]         add_first,
    output logic [N-1:0]         add_second,
    output logic                 add_cin,
    input  logic [N-1:0]         add_sum,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   out_sum,
    output logic                 out_cout,
    output logic                 busy
);

    localparam int W    = N * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [IDXW-1:0] idx_q, idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        add_first  = '0;
        add_second = '0;
        add_cin    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = in_a;
                    idx_d = '0;
                    sum_d = '0;
`ifdef CHUNKED_ADD_SUB_EN
                    // Subtraction is A + ~B + 1; the carry out then means "no borrow".
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub ? 1'b1 : in_cin;
`else
                    b_d     = in_b;
                    carry_d = in_cin;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                add_first                = a_q[idx_q*N +: N];
                add_second               = b_q[idx_q*N +: N];
                add_cin                  = carry_q;
                sum_d[idx_q*N +: N]      = add_sum;
                carry_d                  = add_cout;
                if (idx_q == IDXW'(WORDS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result registers are left untouched on DONE->IDLE so the last sum stays visible.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Self-checking bench for chunked_add_sequencer (N=8, WORDS=4) with an ideal 8-bit adder attached.
module tb_chunked_add_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
`ifdef CHUNKED_ADD_SUB_EN
    logic        in_sub;
`endif
    logic [7:0]  add_first;
    logic [7:0]  add_second;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // External ripple-carry adder stand-in
    assign {add_cout, add_sum} = 9'(add_first) + 9'(add_second) + 9'(add_cin);

    chunked_add_sequencer #(.N(8), .WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef CHUNKED_ADD_SUB_EN
        .in_sub(in_sub),
`endif
        .add_first(add_first), .add_second(add_second), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic; subtraction as A-B with cout = no borrow.
    function automatic logic [32:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic cin, input logic sub);
        logic [32:0] r;
        if (sub) begin
            r[31:0] = a - b;
            r[32]   = (a >= b);
        end else begin
            r = 33'(a) + 33'(b) + 33'(cin);
        end
        return r;
    endfunction

    // Carry entering chunk k equals the carry out of the low 8k bits of the wide operation.
    function automatic logic [3:0] ref_carries(input logic [31:0] a, input logic [31:0] b,
                                               input logic cin, input logic sub);
        logic [63:0] aa, bb, mask, s;
        logic [3:0]  c;
        aa = {32'b0, a};
        bb = sub ? {32'b0, ~b} : {32'b0, b};
        for (int k = 0; k < 4; k++) begin
            mask = (64'h1 << (8 * k)) - 64'h1;
            s    = (aa & mask) + (bb & mask) + (sub ? 64'h1 : {63'b0, cin});
            c[k] = s[8 * k];
        end
        return c;
    endfunction

    // Issues one operation from IDLE (called at posedge+1) and checks everything observable.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub,
                          input logic [31:0] exp_sum, input logic exp_cout);
        logic [31:0] fseq, sseq;
        logic [3:0]  cseq;
        int          lat, k;
        logic [31:0] bexp;
        fseq = '0; sseq = '0; cseq = '0; lat = 0; k = 0;
        bexp = sub ? ~b : b;
        in_a = a; in_b = b; in_cin = cin;
`ifdef CHUNKED_ADD_SUB_EN
        in_sub = sub;
`endif
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            if (k < 4) begin
                fseq[k*8 +: 8] = add_first;
                sseq[k*8 +: 8] = add_second;
                cseq[k]        = add_cin;
                k++;
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd4);
        check({tag, " out_sum"}, 64'(out_sum), 64'(exp_sum));
        check({tag, " out_cout"}, 64'(out_cout), 64'(exp_cout));
        check({tag, " add_first seq"}, 64'(fseq), 64'(a));
        check({tag, " add_second seq"}, 64'(sseq), 64'(bexp));
        check({tag, " add_cin seq"}, 64'(cseq), 64'(ref_carries(a, b, cin, sub)));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " idle in_ready/out_valid"}, {62'b0, in_ready, out_valid}, 64'b10);
        check({tag, " retained sum"}, {31'b0, out_cout, out_sum}, {31'b0, exp_cout, exp_sum});
        $display("[TB] %s a=%08h b=%08h cin=%0d sub=%0d -> sum=%08h cout=%0d", tag, a, b, cin, sub,
                 out_sum, out_cout);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    initial begin
        vec_t        vecs[6];
        logic [32:0] r;
        logic [31:0] ra, rb, held;
        logic        rc, seen;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[1] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0};
        vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        vecs[5] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
`ifdef CHUNKED_ADD_SUB_EN
        in_sub = 1'b0;
`endif
        #1;
        check("reset flags", {59'b0, in_ready, out_valid, busy, out_cout, add_cin}, 64'b10000);
        check("reset out_sum", 64'(out_sum), 64'd0);
        check("reset add operands", {48'b0, add_first, add_second}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
                   vecs[i].exp_sum, vecs[i].exp_cout);
        end

        for (int i = 0; i < 12; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            r  = ref_result(ra, rb, rc, 1'b0);
            run_op($sformatf("rand%0d", i), ra, rb, rc, 1'b0, r[31:0], r[32]);
        end

        // Reset mid-RUN at idx=2
        in_a = 32'hAABBCCDD; in_b = 32'h11223344; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midreset idx2 chunk", 64'(add_first), 64'hBB);
        rst = 1'b1;
        #1;
        check("midreset flags", {61'b0, in_ready, busy, out_valid}, 64'b100);
        check("midreset add outputs", {47'b0, add_first, add_second, add_cin}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("midreset no out_valid", 64'(seen), 64'd0);
        $display("[TB] midreset aborted operation");
        run_op("after_reset", 32'h00000010, 32'h00000020, 1'b0, 1'b0, 32'h00000030, 1'b0);

        // Backpressure with ignored in_valid pulses
        in_a = 32'h01010101; in_b = 32'h02020202; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        held = out_sum;
        check("bp first result", 64'(held), 64'h03030303);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; in_a = $urandom; in_b = $urandom;
            @(posedge clk); #1;
            check($sformatf("bp hold %0d", i), {30'b0, out_valid, in_ready, out_sum},
                  {30'b0, 1'b1, 1'b0, held});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp release", {61'b0, in_ready, out_valid, busy}, 64'b100);
        $display("[TB] backpressure held sum=%08h", held);

        // Back-to-back with in_valid held high
        in_a = 32'h000000FF; in_b = 32'h00000001; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("b2b first accept", 64'(busy), 64'd1);
        in_a = 32'h80000000; in_b = 32'h80000000;
        seen = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("b2b first result", {31'b0, out_valid, out_cout, out_sum}, {31'b0, 1'b1, 1'b0, 32'h100});
        @(posedge clk); #1;
        check("b2b idle gap", {62'b0, in_ready, out_valid}, 64'b10);
        @(posedge clk); #1;
        check("b2b second accept", {62'b0, busy, in_ready}, 64'b10);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("b2b second result", {31'b0, out_valid, out_cout, out_sum}, {31'b0, 1'b1, 1'b1, 32'h0});
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("[TB] back-to-back done");

`ifdef CHUNKED_ADD_SUB_EN
        run_op("sub5-7", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0);
        run_op("sub7-5", 32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            r  = ref_result(ra, rb, rc, 1'b1);
            run_op($sformatf("rsub%0d", i), ra, rb, rc, 1'b1, r[31:0], r[32]);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
